// File: rtl/pwm_reg_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_reg_ctrl
//
// Register bank sitting between the SPI frame deserializer and the PWM engine.
// Completed 16-bit frames ({write, addr[6:0], data[7:0]}) are latched in IDLE
// and evaluated one cycle later in CHECK. Enable registers (addr 0-3) are
// written directly. The duty cycle (addr 4) goes to a shadow register and is
// copied to the live output only on a PWM period boundary. This keeps the
// engine from seeing a duty change in the middle of a period.
//
// Handshake: i_frame_valid is a single-cycle pulse with no back-pressure.
// A frame is taken only when the FSM is IDLE. A pulse that arrives while the
// FSM is in CHECK is dropped and counted as an error. o_busy tells the sender
// when that will happen.
//
// Ports
//   i_clk              system clock
//   i_rst_n            asynchronous active-low reset
//   i_frame_valid      one-cycle pulse, frame present on i_frame_data
//   i_frame_data[15:0] [15] write flag, [14:8] address, [7:0] data
//   i_pwm_period_end   one-cycle pulse at PWM counter wrap
//   o_en_reg_out_7_0   reg 0, output enables 7:0
//   o_en_reg_out_15_8  reg 1, output enables 15:8
//   o_en_reg_pwm_7_0   reg 2, PWM-mode enables 7:0
//   o_en_reg_pwm_15_8  reg 3, PWM-mode enables 15:8
//   o_pwm_duty_cycle   reg 4, live duty cycle
//   o_duty_pending     shadow duty waiting for a period boundary
//   o_commit_pulse     one cycle high after the live duty cycle is updated
//   o_busy             FSM is not IDLE
//   o_err_count        rejected/dropped frames, saturating at 255
//   o_wr_count         accepted writes, wrapping
//   o_dbg_state        FSM state (0 = IDLE, 1 = CHECK)
// ---------------------------------------------------------------------------
module pwm_reg_ctrl #(
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_valid,
  input  logic [15:0] i_frame_data,
  input  logic        i_pwm_period_end,
  output logic [7:0]  o_en_reg_out_7_0,
  output logic [7:0]  o_en_reg_out_15_8,
  output logic [7:0]  o_en_reg_pwm_7_0,
  output logic [7:0]  o_en_reg_pwm_15_8,
  output logic [7:0]  o_pwm_duty_cycle,
  output logic        o_duty_pending,
  output logic        o_commit_pulse,
  output logic        o_busy,
  output logic [7:0]  o_err_count,
  output logic [7:0]  o_wr_count,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_frame_q;
  logic [7:0]  r_reg0;
  logic [7:0]  r_reg1;
  logic [7:0]  r_reg2;
  logic [7:0]  r_reg3;
  logic [7:0]  r_duty;
  logic [7:0]  r_duty_shadow;
  logic        r_duty_pending;
  logic        r_commit_pulse;
  logic [7:0]  r_err_count;
  logic [7:0]  r_wr_count;

  // FSM output decodes
  logic        w_busy;
  logic        w_accept;
  logic        w_drop;
  logic        w_in_check;

  // Frame decode (valid only while in CHECK)
  logic        w_is_write;
  logic [6:0]  w_addr;
  logic [7:0]  w_data;
  logic        w_addr_ok;
  logic        w_wr_ok;
  logic        w_wr_bad;
  logic        w_wr_duty;
  logic        w_commit;
  logic [1:0]  w_err_inc;
  logic [8:0]  w_err_sum;
  logic [7:0]  w_err_nxt;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_frame_valid) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy     = 1'b0;
    w_accept   = 1'b0;
    w_drop     = 1'b0;
    w_in_check = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = i_frame_valid;
      end
      ST_CHECK: begin
        w_busy     = 1'b1;
        w_in_check = 1'b1;
        w_drop     = i_frame_valid;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame decode
  // ---------------------------------------------------------------------
  assign w_is_write = r_frame_q[15];
  assign w_addr     = r_frame_q[14:8];
  assign w_data     = r_frame_q[7:0];
  // 7-bit address zero-extended before comparing to the limit
  assign w_addr_ok  = (32'(w_addr) <= MAX_ADDR);
  assign w_wr_ok    = w_in_check & w_is_write & w_addr_ok;
  assign w_wr_bad   = w_in_check & w_is_write & ~w_addr_ok;
  assign w_wr_duty  = w_wr_ok & (w_addr == 7'd4);
  assign w_commit   = i_pwm_period_end & r_duty_pending;

  // A bad write in CHECK and a dropped pulse can happen in the same cycle;
  // both are counted, and the sum saturates.
  assign w_err_inc  = {1'b0, w_wr_bad} + {1'b0, w_drop};
  assign w_err_sum  = {1'b0, r_err_count} + {7'd0, w_err_inc};
  assign w_err_nxt  = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  // ---------------------------------------------------------------------
  // Frame capture: only in IDLE, so a dropped pulse never overwrites it
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_q <= 16'h0000;
    end else if (w_accept) begin
      r_frame_q <= i_frame_data;
    end
  end

  // ---------------------------------------------------------------------
  // Enable registers and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reg0      <= 8'h00;
      r_reg1      <= 8'h00;
      r_reg2      <= 8'h00;
      r_reg3      <= 8'h00;
      r_wr_count  <= 8'h00;
      r_err_count <= 8'h00;
    end else begin
      if (w_wr_ok) begin
        case (w_addr)
          7'd0:    r_reg0 <= w_data;
          7'd1:    r_reg1 <= w_data;
          7'd2:    r_reg2 <= w_data;
          7'd3:    r_reg3 <= w_data;
          default: ;
        endcase
        r_wr_count <= r_wr_count + 8'd1;
      end
      r_err_count <= w_err_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Duty cycle shadow and commit. The commit reads the shadow value from
  // before any same-cycle write, and a same-cycle write leaves pending set.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty         <= 8'h00;
      r_duty_shadow  <= 8'h00;
      r_duty_pending <= 1'b0;
      r_commit_pulse <= 1'b0;
    end else begin
      r_commit_pulse <= w_commit;
      if (w_commit) begin
        r_duty <= r_duty_shadow;
      end
      if (w_wr_duty) begin
        r_duty_shadow  <= w_data;
        r_duty_pending <= 1'b1;
      end else if (w_commit) begin
        r_duty_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_en_reg_out_7_0  = r_reg0;
  assign o_en_reg_out_15_8 = r_reg1;
  assign o_en_reg_pwm_7_0  = r_reg2;
  assign o_en_reg_pwm_15_8 = r_reg3;
  assign o_pwm_duty_cycle  = r_duty;
  assign o_duty_pending    = r_duty_pending;
  assign o_commit_pulse    = r_commit_pulse;
  assign o_busy            = w_busy;
  assign o_err_count       = r_err_count;
  assign o_wr_count        = r_wr_count;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_pwm_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwm_reg_ctrl
//
// Directed bench for pwm_reg_ctrl. A table of single frames, each with its
// hand-computed expected register state, is applied first. Hand-written
// sequences then cover the duty commit, same-cycle commit and write,
// back-to-back drops, err_count saturation and reset during CHECK.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_pwm_reg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        pwm_period_end;
  logic [7:0]  en_out_lo;
  logic [7:0]  en_out_hi;
  logic [7:0]  en_pwm_lo;
  logic [7:0]  en_pwm_hi;
  logic [7:0]  duty;
  logic        duty_pending;
  logic        commit_pulse;
  logic        busy;
  logic [7:0]  err_count;
  logic [7:0]  wr_count;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // expected state
  logic [7:0] e_r0, e_r1, e_r2, e_r3, e_duty, e_wr, e_err;
  logic       e_pend;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  r0, r1, r2, r3, duty;
    logic        pend;
    logic [7:0]  wr, err;
  } vec_t;

  vec_t vecs[10];

  pwm_reg_ctrl #(.MAX_ADDR(4)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_frame_valid     (frame_valid),
    .i_frame_data      (frame_data),
    .i_pwm_period_end  (pwm_period_end),
    .o_en_reg_out_7_0  (en_out_lo),
    .o_en_reg_out_15_8 (en_out_hi),
    .o_en_reg_pwm_7_0  (en_pwm_lo),
    .o_en_reg_pwm_15_8 (en_pwm_hi),
    .o_pwm_duty_cycle  (duty),
    .o_duty_pending    (duty_pending),
    .o_commit_pulse    (commit_pulse),
    .o_busy            (busy),
    .o_err_count       (err_count),
    .o_wr_count        (wr_count),
    .o_dbg_state       (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_commit);
    chk({tag, " reg0"},    en_out_lo, e_r0);
    chk({tag, " reg1"},    en_out_hi, e_r1);
    chk({tag, " reg2"},    en_pwm_lo, e_r2);
    chk({tag, " reg3"},    en_pwm_hi, e_r3);
    chk({tag, " duty"},    duty, e_duty);
    chk({tag, " pending"}, {7'd0, duty_pending}, {7'd0, e_pend});
    chk({tag, " commit"},  {7'd0, commit_pulse}, {7'd0, exp_commit});
    chk({tag, " busy"},    {7'd0, busy}, 8'd0);
    chk({tag, " wr_cnt"},  wr_count, e_wr);
    chk({tag, " err_cnt"}, err_count, e_err);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // frame accepted at edge T, evaluated at edge T+1; returns after T+1
  task automatic send_frame(input logic [15:0] f, input logic pe_at_check);
    frame_valid = 1'b1;
    frame_data  = f;
    tick();
    frame_valid = 1'b0;
    chk("busy after accept", {7'd0, busy}, 8'd1);
    pwm_period_end = pe_at_check;
    tick();
    pwm_period_end = 1'b0;
  endtask

  task automatic pulse_period_end();
    pwm_period_end = 1'b1;
    tick();
    pwm_period_end = 1'b0;
  endtask

  task automatic zero_expect();
    e_r0 = 8'h00; e_r1 = 8'h00; e_r2 = 8'h00; e_r3 = 8'h00;
    e_duty = 8'h00; e_pend = 1'b0; e_wr = 8'h00; e_err = 8'h00;
  endtask

  initial begin
    int n_commit;

    //                  frame     r0     r1     r2     r3     duty  pend  wr     err
    vecs[0] = '{16'h80A5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'd1, 8'd0};
    vecs[1] = '{16'h815A, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, 8'd2, 8'd0};
    vecs[2] = '{16'h823C, 8'hA5, 8'h5A, 8'h3C, 8'h00, 8'h00, 1'b0, 8'd3, 8'd0};
    vecs[3] = '{16'h83C3, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'd4, 8'd0};
    vecs[4] = '{16'h8500, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'd4, 8'd1};
    vecs[5] = '{16'h0012, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'd4, 8'd1};
    vecs[6] = '{16'h7F77, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'd4, 8'd1};
    vecs[7] = '{16'hFF11, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b0, 8'd4, 8'd2};
    vecs[8] = '{16'h8480, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b1, 8'd5, 8'd2};
    vecs[9] = '{16'h8001, 8'h01, 8'h5A, 8'h3C, 8'hC3, 8'h00, 1'b1, 8'd6, 8'd2};

    // reset block
    rst_n = 1'b0;
    frame_valid = 1'b0;
    frame_data = 16'h0000;
    pwm_period_end = 1'b0;
    zero_expect();
    #12;
    check_all("in reset", 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all("after reset", 1'b0);
    chk("state idle after reset", {7'd0, dbg_state}, 8'd0);

    // table-driven single frames
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].frame, 1'b0);
      e_r0 = vecs[i].r0; e_r1 = vecs[i].r1; e_r2 = vecs[i].r2; e_r3 = vecs[i].r3;
      e_duty = vecs[i].duty; e_pend = vecs[i].pend;
      e_wr = vecs[i].wr; e_err = vecs[i].err;
      check_all($sformatf("vec%0d", i), 1'b0);
    end

    // pending 0x80 commits on the boundary, pulse lasts one cycle
    pulse_period_end();
    e_duty = 8'h80; e_pend = 1'b0;
    check_all("commit 80", 1'b1);
    tick();
    check_all("commit 80 pulse end", 1'b0);
    // boundary with nothing pending does nothing
    pulse_period_end();
    check_all("idle boundary", 1'b0);
    tick();
    check_all("idle boundary +1", 1'b0);

    // last write wins, single commit
    send_frame(16'h8440, 1'b0);
    send_frame(16'h84C0, 1'b0);
    e_wr = 8'd8; e_pend = 1'b1;
    check_all("two shadow writes", 1'b0);
    n_commit = 0;
    pulse_period_end();
    if (commit_pulse) n_commit++;
    e_duty = 8'hC0; e_pend = 1'b0;
    check_all("commit C0", 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) pwm_period_end = 1'b1;
      tick();
      pwm_period_end = 1'b0;
      if (commit_pulse) n_commit++;
    end
    chk("single commit count", 8'(n_commit), 8'd1);
    check_all("after C0", 1'b0);

    // boundary during CHECK of a new write, older shadow pending
    send_frame(16'h8430, 1'b0);
    send_frame(16'h8450, 1'b1);
    e_wr = 8'd10; e_duty = 8'h30; e_pend = 1'b1;
    check_all("commit old shadow 30", 1'b1);
    pulse_period_end();
    e_duty = 8'h50; e_pend = 1'b0;
    check_all("commit 50", 1'b1);

    // boundary during CHECK, nothing pending before the write
    send_frame(16'h8410, 1'b0);
    pulse_period_end();
    e_wr = 8'd11; e_duty = 8'h10;
    check_all("commit 10", 1'b1);
    send_frame(16'h8420, 1'b1);
    e_wr = 8'd12; e_pend = 1'b1;
    check_all("write 20 at boundary", 1'b0);
    pulse_period_end();
    e_duty = 8'h20; e_pend = 1'b0;
    check_all("commit 20", 1'b1);
    tick();

    // back-to-back pulses: second frame is dropped
    frame_valid = 1'b1;
    frame_data = 16'h8166;
    tick();
    chk("b2b busy", {7'd0, busy}, 8'd1);
    frame_data = 16'h8299;
    tick();
    frame_valid = 1'b0;
    e_r1 = 8'h66; e_wr = 8'd13; e_err = 8'd3;
    check_all("b2b", 1'b0);
    tick();
    tick();
    check_all("b2b settled", 1'b0);

    // err_count saturation
    for (int k = 0; k < 300; k++) begin
      send_frame(16'h8500, 1'b0);
    end
    e_err = 8'hFF;
    check_all("err saturate", 1'b0);
    send_frame(16'hFF00, 1'b0);
    check_all("err held", 1'b0);

    // reset during CHECK of a reg2 write
    frame_valid = 1'b1;
    frame_data = 16'h8277;
    tick();
    frame_valid = 1'b0;
    chk("busy before reset", {7'd0, busy}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    zero_expect();
    check_all("async reset in CHECK", 1'b0);
    tick();
    check_all("held reset", 1'b0);
    rst_n = 1'b1;
    tick();
    check_all("after reset release", 1'b0);
    tick();
    check_all("after reset release +1", 1'b0);
    chk("state idle after abort", {7'd0, dbg_state}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
